// File: rtl/traffic_ctrl_nway.sv
// traffic_ctrl_nway
// N-way traffic-light sequencer. Each approach gets green, then yellow, then an
// all-red clearance. Timing advances only on the external tick strobe. Night
// flashing mode is entered at an all-red boundary. The optional pedestrian
// walk phase is compiled in with the TRAFFIC_PED_EN macro.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tick      one-cycle timing strobe
//   flash_en  night-mode request (level)
//   ped_req   pedestrian request (any-length pulse)
//   lights    per way i, bits [3i+2:3i] = {red,yellow,green}
//   cur_way   way owning the current / most recent green
//   walk      pedestrian walk lamp
//   ped_ack   one-cycle pulse in the first cycle of WALK
//
// state  | meaning
// GREEN  | cur_way has green, others red
// YELLOW | cur_way has yellow, others red
// ALLRED | clearance, every way red; decides flash / walk / next way
// WALK   | every way red, walk lamp on (TRAFFIC_PED_EN only)
// FLASH  | night mode, all ways blink yellow on each tick
module traffic_ctrl_nway #(
  parameter int NUM_WAYS = 4,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  flash_en,
  input  logic                  ped_req,
  output logic [3*NUM_WAYS-1:0] lights,
  output logic [2:0]            cur_way,
  output logic                  walk,
  output logic                  ped_ack
);

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_FLASH  = 3'd3
`ifdef TRAFFIC_PED_EN
    , ST_WALK = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_WAY  = 3'(NUM_WAYS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       cur_way_q, cur_way_d;
  logic             flash_q, flash_d;
  logic [2:0]       next_way;
  logic             timer_zero;

`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] PED_LD = CNT_W'(PED_T - 1);
  logic pending_q, pending_d;
  logic ped_ack_q, ped_ack_d;
`else
  localparam int unused_ped_t = PED_T;
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  assign next_way   = (cur_way_q == LAST_WAY) ? 3'd0 : cur_way_q + 3'd1;
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cur_way_d = cur_way_q;
    flash_d   = flash_q;
`ifdef TRAFFIC_PED_EN
    // a request arriving on the WALK-entry edge is overridden below and lost
    pending_d = pending_q | ped_req;
    ped_ack_d = 1'b0;
`endif
    case (state_q)
      ST_GREEN: begin
        if (tick) begin
          if (timer_zero) begin
            state_d = ST_YELLOW;
            timer_d = YELLOW_LD;
          end else begin
            timer_d = timer_q - CNT_ONE;
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (timer_zero) begin
            state_d = ST_ALLRED;
            timer_d = ALLRED_LD;
          end else begin
            timer_d = timer_q - CNT_ONE;
          end
        end
      end
      ST_ALLRED: begin
        if (tick) begin
          if (!timer_zero) begin
            timer_d = timer_q - CNT_ONE;
          end else if (flash_en) begin
            state_d = ST_FLASH;
            flash_d = 1'b1;
`ifdef TRAFFIC_PED_EN
          end else if (pending_q) begin
            state_d   = ST_WALK;
            timer_d   = PED_LD;
            pending_d = 1'b0;
            ped_ack_d = 1'b1;
`endif
          end else begin
            state_d   = ST_GREEN;
            timer_d   = GREEN_LD;
            cur_way_d = next_way;
          end
        end
      end
`ifdef TRAFFIC_PED_EN
      ST_WALK: begin
        if (tick) begin
          if (timer_zero) begin
            state_d   = ST_GREEN;
            timer_d   = GREEN_LD;
            cur_way_d = next_way;
          end else begin
            timer_d = timer_q - CNT_ONE;
          end
        end
      end
`endif
      ST_FLASH: begin
        if (tick) begin
          if (!flash_en) begin
            // park on the last way so the clearance hands green to way 0
            state_d   = ST_ALLRED;
            timer_d   = ALLRED_LD;
            cur_way_d = LAST_WAY;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
      default: begin
        state_d   = ST_ALLRED;
        timer_d   = ALLRED_LD;
        cur_way_d = LAST_WAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GREEN;
      timer_q   <= GREEN_LD;
      cur_way_q <= 3'd0;
      flash_q   <= 1'b0;
`ifdef TRAFFIC_PED_EN
      pending_q <= 1'b0;
      ped_ack_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_way_q <= cur_way_d;
      flash_q   <= flash_d;
`ifdef TRAFFIC_PED_EN
      pending_q <= pending_d;
      ped_ack_q <= ped_ack_d;
`endif
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      lights[3*i +: 3] = 3'b100;
      if (state_q == ST_FLASH) begin
        lights[3*i +: 3] = flash_q ? 3'b010 : 3'b000;
      end else if (3'(i) == cur_way_q) begin
        if (state_q == ST_GREEN)  lights[3*i +: 3] = 3'b001;
        if (state_q == ST_YELLOW) lights[3*i +: 3] = 3'b010;
      end
    end
  end

  assign cur_way = cur_way_q;

`ifdef TRAFFIC_PED_EN
  assign walk    = (state_q == ST_WALK);
  assign ped_ack = ped_ack_q;
`else
  assign walk    = 1'b0;
  assign ped_ack = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway with NUM_WAYS=3, GREEN_T=5, YELLOW_T=1,
// ALLRED_T=1, PED_T=4. Sample index c counts rising edges since reset release
// (c=0 is the reset state). Pedestrian expectations follow TRAFFIC_PED_EN.
module tb_traffic_ctrl_nway;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       flash_en = 1'b0;
  logic       ped_req = 1'b0;
  logic [8:0] lights;
  logic [2:0] cur_way;
  logic       walk;
  logic       ped_ack;

  int errors = 0;
  int checks = 0;

  traffic_ctrl_nway #(
    .NUM_WAYS(3), .GREEN_T(5), .YELLOW_T(1), .ALLRED_T(1), .PED_T(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .flash_en(flash_en), .ped_req(ped_req),
    .lights(lights), .cur_way(cur_way), .walk(walk), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] way_lights(input int w, input logic [2:0] code);
    logic [8:0] l;
    for (int i = 0; i < 3; i++) l[3*i +: 3] = (i == w) ? code : 3'b100;
    return l;
  endfunction

  function automatic logic [8:0] all_lights(input logic [2:0] code);
    return {code, code, code};
  endfunction

  // plain rotation: 7-tick period per way, green 5, yellow 1, all-red 1
  function automatic logic [8:0] rot_exp(input int c);
    int p = c % 7;
    int w = (c / 7) % 3;
    if (p < 5)  return way_lights(w, 3'b001);
    if (p == 5) return way_lights(w, 3'b010);
    return all_lights(3'b100);
  endfunction

  function automatic logic [31:0] rot_way(input int c);
    return 32'((c / 7) % 3);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state and plain rotation
    tick = 1'b1;
    do_reset();
    chk("rst lights", lights, way_lights(0, 3'b001));
    chk("rst cur_way", cur_way, 0);
    chk("rst walk", walk, 0);
    chk("rst ped_ack", ped_ack, 0);
    for (int c = 1; c <= 21; c++) begin
      step();
      chk($sformatf("rot lights c%0d", c), lights, rot_exp(c));
      chk($sformatf("rot way c%0d", c), cur_way, rot_way(c));
    end

    // tick every 4th clock stretches every phase 4x
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      tick = (k % 4 == 0);
      step();
      chk($sformatf("slow lights k%0d", k), lights, rot_exp(k / 4));
      chk($sformatf("slow way k%0d", k), cur_way, rot_way(k / 4));
    end
    tick = 1'b1;

    // flash requested mid-green of way1
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c <= 13) begin
        chk($sformatf("fl lights c%0d", c), lights, rot_exp(c));
      end else if (c <= 16) begin
        chk($sformatf("fl blink c%0d", c), lights,
            all_lights((c % 2 == 0) ? 3'b010 : 3'b000));
        chk($sformatf("fl way c%0d", c), cur_way, 1);
      end else if (c == 17) begin
        chk("fl exit allred", lights, all_lights(3'b100));
        chk("fl exit way", cur_way, 2);
      end else begin
        chk("fl resume lights", lights, way_lights(0, 3'b001));
        chk("fl resume way", cur_way, 0);
      end
      if (c == 8)  flash_en = 1'b1;
      if (c == 16) flash_en = 1'b0;
    end

    // pedestrian request pulsed in cycle 2
    do_reset();
    step();
    ped_req = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      step();
      ped_req = 1'b0;
`ifdef TRAFFIC_PED_EN
      if (c <= 6) begin
        chk($sformatf("ped lights c%0d", c), lights, rot_exp(c));
        chk($sformatf("ped walk c%0d", c), walk, 0);
      end else if (c <= 10) begin
        chk($sformatf("ped red c%0d", c), lights, all_lights(3'b100));
        chk($sformatf("ped walk c%0d", c), walk, 1);
        chk($sformatf("ped ack c%0d", c), ped_ack, (c == 7) ? 1 : 0);
        chk($sformatf("ped way c%0d", c), cur_way, 0);
      end else begin
        chk("ped after lights", lights, way_lights(1, 3'b001));
        chk("ped after walk", walk, 0);
      end
`else
      chk($sformatf("noped lights c%0d", c), lights, rot_exp(c));
      chk($sformatf("noped walk c%0d", c), walk, 0);
      chk($sformatf("noped ack c%0d", c), ped_ack, 0);
`endif
    end

    // flash and pending request at the same all-red exit
    do_reset();
    flash_en = 1'b1;
    ped_req  = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      ped_req = 1'b0;
      if (c <= 6) begin
        chk($sformatf("fp lights c%0d", c), lights, rot_exp(c));
      end else if (c == 7) begin
        chk("fp flash on", lights, all_lights(3'b010));
        chk("fp walk off", walk, 0);
      end else if (c == 8) begin
        chk("fp flash dark", lights, all_lights(3'b000));
      end else if (c == 9) begin
        chk("fp allred", lights, all_lights(3'b100));
        chk("fp allred way", cur_way, 2);
      end else if (c <= 13) begin
`ifdef TRAFFIC_PED_EN
        chk($sformatf("fp walk red c%0d", c), lights, all_lights(3'b100));
        chk($sformatf("fp walk c%0d", c), walk, 1);
        chk($sformatf("fp ack c%0d", c), ped_ack, (c == 10) ? 1 : 0);
`else
        chk($sformatf("fp green c%0d", c), lights, way_lights(0, 3'b001));
        chk($sformatf("fp walk c%0d", c), walk, 0);
`endif
      end else begin
        chk("fp resume lights", lights, way_lights(0, 3'b001));
        chk("fp resume way", cur_way, 0);
        chk("fp resume walk", walk, 0);
      end
      if (c == 8) flash_en = 1'b0;
    end

    // asynchronous reset mid-yellow of way2 with a pending request
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      step();
      ped_req = (c == 15);
    end
    ped_req = 1'b0;
    chk("ar yellow way2", lights, way_lights(2, 3'b010));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar async lights", lights, way_lights(0, 3'b001));
    chk("ar async way", cur_way, 0);
    chk("ar async walk", walk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("ar lights c%0d", c), lights, rot_exp(c));
      chk($sformatf("ar walk c%0d", c), walk, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_nway.md
# traffic_ctrl_nway

Parametrised N-way traffic-light controller, the successor to the two-way fixed-timing controller. It sequences NUM_WAYS approaches through green, yellow and all-red phases with configurable durations, and advances timing on an external `tick` strobe rather than on every clock. It adds a night flashing mode and an optional pedestrian walk phase with request/acknowledge. It sits at intersection top level, fed by a 1 Hz tick generator.

## Interface
- NUM_WAYS, 4, number of approaches (2..8)
- GREEN_T, 5, green duration in ticks (1..2^CNT_W)
- YELLOW_T, 1, yellow duration in ticks (1..2^CNT_W)
- ALLRED_T, 1, all-red clearance in ticks (1..2^CNT_W)
- PED_T, 4, walk duration in ticks (1..2^CNT_W)
- CNT_W, 4, phase timer width

- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle timing strobe; timer advances only when high
- flash_en  in  1  night-mode request, level
- ped_req  in  1  pedestrian request, any-length pulse
- lights  out  3*NUM_WAYS  per way i, bits [3i+2:3i] = {red,yellow,green}; 001 green, 010 yellow, 100 red, 000 dark
- cur_way  out  3  index of way owning current/most recent green
- walk  out  1  pedestrian walk lamp
- ped_ack  out  1  one-cycle pulse on WALK entry

## Operation
- States: GREEN, YELLOW, ALLRED, WALK, FLASH. Moore outputs decoded from state, cur_way and flash phase.
- Phase timer loads T-1 on entry; on tick with timer>0 decrement; on tick with timer==0 leave phase. Each phase lasts exactly T ticks.
- GREEN: lights[cur_way]=001, others 100. -> YELLOW.
- YELLOW: lights[cur_way]=010, others 100. -> ALLRED.
- ALLRED: all 100. Exit priority: flash_en high -> FLASH; else ped pending -> WALK; else cur_way advances (NUM_WAYS-1 wraps to 0) -> GREEN.
- WALK: all 100, walk=1. -> cur_way advances -> GREEN.
- FLASH: flash phase bit toggles each tick; all ways 010 when bit=1, 000 when bit=0; bit=1 on entry. On tick with flash_en low: cur_way <= NUM_WAYS-1 -> ALLRED (timer ALLRED_T-1). The following advance yields way 0.
- flash_en is honoured only at ALLRED exit, never mid-green or mid-yellow.
- Ped pending flag: set by ped_req in any cycle. Cleared on the WALK-entry edge; a ped_req on that same edge is dropped. A ped_req during WALK or FLASH sets pending again.
- Illegal state -> ALLRED, cur_way=NUM_WAYS-1.

## Timing
- Reset values: state GREEN, cur_way 0, timer GREEN_T-1, lights way0=001 others 100, walk 0, ped_ack 0, pending 0, flash bit 0.
- Reset mid-operation takes effect immediately and asynchronously; pending requests are lost.
- Transition latency: outputs change on the clk edge sampling the terminal tick; no extra cycle.
- ped_ack is high for exactly the first clk cycle of WALK, regardless of tick.
- Full rotation with no walk/flash: NUM_WAYS*(GREEN_T+YELLOW_T+ALLRED_T) ticks.
- Tick held high every cycle is legal: durations are then counted in clocks.

## Configuration
- TRAFFIC_PED_EN defined: WALK state, pending flag, walk and ped_ack are implemented as above.
- TRAFFIC_PED_EN undefined: WALK state and pending flag are removed; ped_req is ignored; walk and ped_ack are tied 0; ALLRED exit is flash_en -> FLASH, else next GREEN. PED_T is unused.

## Test plan
Parameters for all scenarios: NUM_WAYS=3, GREEN_T=5, YELLOW_T=1, ALLRED_T=1, PED_T=4, tick=1.
- Release reset, run 21 cycles -> way0 001 for 5 cycles, 010 for 1, all 100 for 1; then way1, then way2; cycle 22 shows way0 001 with cur_way=0.
- TRAFFIC_PED_EN, pulse ped_req in cycle 2 -> after way0 ALLRED: walk=1 for 4 cycles, ped_ack high in the first of those only, then way1 001.
- Tick every 4th cycle -> every phase stretched 4x (way0 green 20 clocks); no state change in cycles without tick.
- Assert flash_en during way1 green -> way1 still finishes green/yellow/all-red, then lights alternate 010/000 (all ways) per tick; deassert -> 1 tick all 100, then way0 001.
- flash_en and pending ped_req both present at ALLRED exit -> FLASH wins, pending is kept; after flash exit ALLRED -> WALK -> way0 green.
- Drop rst_n mid-yellow of way2 with pending request -> same cycle lights way0=001, others 100, walk 0; no WALK occurs afterwards.
